cnt_ctrl: RTL and testbench

CNT_CTRL -- requirements
Module: cnt_ctrl

---
 rtl/cnt_ctrl_pkg.sv | 11 +
 rtl/cnt_ctrl_edge_sync.sv | 14 +
 rtl/cnt_ctrl.sv | 72 +++++++
 tb/tb_cnt_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_ctrl_pkg.sv
// cnt_ctrl_pkg: state encoding and default sizing for the counter controller
package cnt_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;
    localparam int DEF_WIDTH = 3;
    localparam int DEF_DIV   = 50000000;
endpackage

// File: rtl/cnt_ctrl_edge_sync.sv
// edge_sync: 2-flop synchronizer followed by a rising-edge detector
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);
    logic s1, s2, s3;
    // shift the raw level through two sync flops and one history flop
    always_ff @(posedge clk or posedge rst)
        if (rst) {s1, s2, s3} <= 3'b000;
        else     {s1, s2, s3} <= {d, s1, s2};
    assign pulse = s2 & ~s3;
endmodule

// File: rtl/cnt_ctrl.sv
// cnt_ctrl: load/run/done controller for an external counter; CNT_CTRL_AUTORELOAD_EN makes a terminal count reload and continue
module cnt_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic [WIDTH-1:0] count,
    output logic             le,
    output logic [WIDTH-1:0] load_data,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    state_t cur, nxt, term_st;
    logic [PW-1:0] pre, pre_nxt;
    logic start_p, stop_p;
    edge_sync u_start (.clk(clk), .rst(rst), .d(start), .pulse(start_p));
    edge_sync u_stop  (.clk(clk), .rst(rst), .d(stop),  .pulse(stop_p));
`ifdef CNT_CTRL_AUTORELOAD_EN
    // a zero-length loop would reload forever, so it finishes instead
    assign term_st = (start_val == term_val) ? DONE : LOAD;
`else
    assign term_st = DONE;
`endif
    // state and prescaler registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cur <= IDLE;
            pre <= '0;
        end else begin
            cur <= nxt;
            pre <= pre_nxt;
        end
    // next state, prescaler and one-cycle strobes; stop always outranks start
    always_comb begin
        nxt     = cur;
        pre_nxt = pre;
        le      = 1'b0;
        cnt_en  = 1'b0;
        case (cur)
            IDLE: nxt = (start_p && !stop_p) ? LOAD : IDLE;
            LOAD: begin
                le      = 1'b1;
                pre_nxt = '0;
                nxt     = stop_p ? IDLE : RUN;
            end
            RUN:
                if (stop_p) nxt = IDLE;
                else if (count == term_val) nxt = term_st;
                else if (pre == PRE_MAX) begin
                    cnt_en  = 1'b1;
                    pre_nxt = '0;
                end else pre_nxt = pre + 1'b1;
            DONE: nxt = stop_p ? IDLE : (start_p ? LOAD : DONE);
            default: nxt = IDLE;
        endcase
    end
    assign load_data = start_val;
    assign busy      = (cur == LOAD) || (cur == RUN);
    assign done      = (cur == DONE);
    assign state     = cur;
endmodule

// File: tb/tb_cnt_ctrl.sv
// tb_cnt_ctrl: scoreboard bench for cnt_ctrl with DIV=4, WIDTH=3 and an attached counter model
module tb_cnt_ctrl;
    logic clk = 1'b0;
    logic rst, start, stop;
    logic [2:0] start_val, term_val, count, load_data;
    logic le, cnt_en, busy, done;
    logic [1:0] state;
    logic [2:0] exp_q[$];
    int checks = 0, errors = 0, le_n = 0, ce_n = 0, gap = 0;

    cnt_ctrl #(.WIDTH(3), .DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .start_val(start_val), .term_val(term_val), .count(count),
        .le(le), .load_data(load_data), .cnt_en(cnt_en),
        .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // controlled counter: loads on le, increments modulo 8 on cnt_en
    always @(posedge clk)
        if (le) count <= load_data;
        else if (cnt_en) count <= count + 3'd1;

    // pulse monitor: counts strobes, checks tick spacing and the expected pre-tick count
    always @(negedge clk) begin
        if (le) begin le_n++; gap = 0; end else gap++;
        if (cnt_en) begin
            ce_n++;
            checks++;
            if (gap !== 4) begin errors++; $display("FAIL tick_gap: got %0d want 4", gap); end
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL unexpected_tick: count=%0d with empty scoreboard", count);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (count !== e) begin errors++; $display("FAIL tick_count: got %0d want %0d", count, e); end
            end
            gap = 0;
        end
    end

    task automatic wait_state(input logic [1:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (state == s) begin ok = 1'b1; break; end
        end
    endtask

    task automatic pulse_in(input bit do_start, input bit do_stop);
        @(negedge clk);
        start = do_start; stop = do_stop;
        repeat (3) @(negedge clk);
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic push_run(input logic [2:0] sv, input logic [2:0] tv);
        logic [2:0] c;
        c = sv;
        while (c != tv) begin exp_q.push_back(c); c = c + 3'd1; end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; stop = 1'b0; start_val = 3'd0; term_val = 3'd0; count = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
        checks++;
        if ({le, cnt_en, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs: le/cnt_en/busy/done got %b want 0000", {le, cnt_en, busy, done});
        end
        rst = 1'b0;
    endtask

    task automatic test_count(input logic [2:0] sv, input logic [2:0] tv, input int ticks);
        int le0, ce0;
        bit ok;
        start_val = sv; term_val = tv;
        push_run(sv, tv);
        le0 = le_n; ce0 = ce_n;
        pulse_in(1'b1, 1'b0);
        wait_state(2'b11, ok);
        checks++;
        if (!ok || done !== 1'b1) begin errors++; $display("FAIL count_%0d_%0d_done: state=%b done=%b want 11/1", sv, tv, state, done); end
        checks++;
        if (le_n - le0 !== 1) begin errors++; $display("FAIL count_%0d_%0d_le: got %0d pulses want 1", sv, tv, le_n - le0); end
        checks++;
        if (ce_n - ce0 !== ticks) begin errors++; $display("FAIL count_%0d_%0d_ticks: got %0d want %0d", sv, tv, ce_n - ce0, ticks); end
        checks++;
        if (count !== tv || busy !== 1'b0) begin errors++; $display("FAIL count_%0d_%0d_final: count=%0d busy=%b want %0d/0", sv, tv, count, busy, tv); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL count_%0d_%0d_scoreboard: %0d ticks missing", sv, tv, exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        test_count(3'd6, 3'd1, 3);
        test_count(3'd4, 3'd4, 0);
    endtask

    task automatic test_stop;
        int ce_snap;
        bit ok;
        start_val = 3'd2; term_val = 3'd7;
        exp_q.push_back(3'd2);
        pulse_in(1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (state == 2'b10 && count == 3'd3) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stop_reach3: count=%0d state=%b want 3/10", count, state); end
        ce_snap = ce_n;
        stop = 1'b1;
        repeat (3) @(negedge clk);
        stop = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL stop_state: got %b want 00", state); end
        checks++;
        if (count !== 3'd3 || ce_n !== ce_snap) begin errors++; $display("FAIL stop_hold: count=%0d extra_ticks=%0d want 3/0", count, ce_n - ce_snap); end
        push_run(3'd2, 3'd7);
        pulse_in(1'b1, 1'b0);
        wait_state(2'b10, ok);
        checks++;
        if (!ok || count !== 3'd2) begin errors++; $display("FAIL stop_reload: count=%0d want 2", count); end
        wait_state(2'b11, ok);
        checks++;
        if (!ok || count !== 3'd7 || exp_q.size() != 0) begin
            errors++; $display("FAIL stop_rerun: count=%0d state=%b left=%0d want 7/11/0", count, state, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous;
        int le0;
        le0 = le_n;
        pulse_in(1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (state !== 2'b00) begin errors++; $display("FAIL simul_from_done: got %b want 00", state); end
        pulse_in(1'b1, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (state !== 2'b00 || le_n !== le0) begin errors++; $display("FAIL simul_from_idle: state=%b le=%0d want 00/0", state, le_n - le0); end
    endtask

    task automatic test_async_reset;
        int le0;
        bit ok;
        start_val = 3'd0; term_val = 3'd7;
        push_run(3'd0, 3'd7);
        pulse_in(1'b1, 1'b0);
        wait_state(2'b10, ok);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state, le, cnt_en, busy, done} !== 6'b000000) begin
            errors++; $display("FAIL async_reset: state/le/cnt_en/busy/done got %b want 000000", {state, le, cnt_en, busy, done});
        end
        exp_q.delete();
        #4 rst = 1'b0;
        le0 = le_n;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (state !== 2'b00 || le_n !== le0) begin errors++; $display("FAIL async_release: state=%b le=%0d want 00/0", state, le_n - le0); end
    endtask

    task automatic test_start_across_reset;
        bit ok;
        start_val = 3'd5; term_val = 3'd5;
        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_state(2'b11, ok);
        start = 1'b0;
        checks++;
        if (!ok || done !== 1'b1) begin errors++; $display("FAIL start_across_reset: state=%b want 11", state); end
    endtask

    task automatic test_autoreload;
        int le0, ce0;
        bit ok;
        start_val = 3'd1; term_val = 3'd3;
        repeat (3) begin exp_q.push_back(3'd1); exp_q.push_back(3'd2); end
        le0 = le_n; ce0 = ce_n;
        pulse_in(1'b1, 1'b0);
        for (int i = 0; i < 200 && ce_n - ce0 < 6; i++) begin @(negedge clk); #1; end
        checks++;
        if (ce_n - ce0 !== 6) begin errors++; $display("FAIL reload_ticks: got %0d want 6", ce_n - ce0); end
        checks++;
        if (le_n - le0 !== 3 || busy !== 1'b1) begin errors++; $display("FAIL reload_loops: le=%0d busy=%b want 3/1", le_n - le0, busy); end
        pulse_in(1'b0, 1'b1);
        wait_state(2'b00, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL reload_stop: state=%b want 00", state); end
        exp_q.delete();
        start_val = 3'd4; term_val = 3'd4;
        le0 = le_n; ce0 = ce_n;
        pulse_in(1'b1, 1'b0);
        wait_state(2'b11, ok);
        checks++;
        if (!ok || le_n - le0 !== 1 || ce_n !== ce0) begin
            errors++; $display("FAIL reload_equal: state=%b le=%0d ticks=%0d want 11/1/0", state, le_n - le0, ce_n - ce0);
        end
    endtask

    initial begin
        test_reset();
`ifdef CNT_CTRL_AUTORELOAD_EN
        test_autoreload();
`else
        test_count(3'd2, 3'd5, 3);
        test_back_to_back();
        test_stop();
`endif
        test_simultaneous();
        test_async_reset();
        test_start_across_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
